// File: rtl/framebuffer_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter slice.
// Holds the frame RAM address geometry, the default pixel width and the
// front/back buffer swap state encoding, plus the RAM address packing helper.
package framebuffer_arbiter_pkg;

  localparam int ROW_BITS            = 4;
  localparam int COL_BITS            = 6;
  localparam int ADDR_BITS           = 1 + ROW_BITS + COL_BITS;
  localparam int PIXEL_WIDTH_DEFAULT = 18;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SWAP_WAIT = 2'd1,
    ST_SWAP      = 2'd2
  } swap_state_t;

  function automatic logic [ADDR_BITS-1:0] pack_addr(
    input logic                bank,
    input logic [ROW_BITS-1:0] row,
    input logic [COL_BITS-1:0] col
  );
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/framebuffer_arbiter_write_fifo.sv
// write_fifo: synchronous show-ahead FIFO buffering host pixel writes.
// Ports:
//   clk_in    - clock, rising edge
//   reset     - synchronous active-high, empties the FIFO
//   push      - write push_data (ignored when full)
//   push_data - entry to store
//   pop       - discard the head entry (ignored when empty)
//   pop_data  - current head entry, valid whenever !empty
//   full      - DEPTH entries stored
//   empty     - no entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
module write_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                do_push;
  logic                do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_BITS+1)'(1);
        2'b01:   count <= count - (PTR_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PTR_BITS+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one single-port frame RAM between the display
// scan (highest priority, reads the front buffer) and buffered host writes
// (drained into the back buffer on free cycles), and swaps front/back
// buffers at a frame boundary once all pending writes have landed.
// Ports:
//   clk_in, reset                - clock; synchronous active-high reset
//   disp_req/row/col             - display read request for one pixel
//   disp_frame_end               - pulse marking the end of a frame
//   disp_data, disp_valid        - read result, one cycle after disp_req
//   host_wr_valid/ready          - host write handshake
//   host_wr_row/col/data         - host write payload
//   host_swap_req, host_swap_ack - swap request pulse / completion pulse
//   active_bank                  - bank currently displayed
//   ram_addr/we/wdata/rdata      - frame RAM port, 1-cycle read latency
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int PIXEL_WIDTH   = PIXEL_WIDTH_DEFAULT,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   disp_req,
  input  logic [ROW_BITS-1:0]    disp_row,
  input  logic [COL_BITS-1:0]    disp_col,
  input  logic                   disp_frame_end,
  output logic [PIXEL_WIDTH-1:0] disp_data,
  output logic                   disp_valid,
  input  logic                   host_wr_valid,
  output logic                   host_wr_ready,
  input  logic [ROW_BITS-1:0]    host_wr_row,
  input  logic [COL_BITS-1:0]    host_wr_col,
  input  logic [PIXEL_WIDTH-1:0] host_wr_data,
  input  logic                   host_swap_req,
  output logic                   host_swap_ack,
  output logic                   active_bank,
  output logic [ADDR_BITS-1:0]   ram_addr,
  output logic                   ram_we,
  output logic [PIXEL_WIDTH-1:0] ram_wdata,
  input  logic [PIXEL_WIDTH-1:0] ram_rdata
);

  localparam int ENTRY_BITS = ROW_BITS + COL_BITS + PIXEL_WIDTH;

  swap_state_t            state;
  logic                   bank_q;
  logic                   valid_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [ADDR_BITS-1:0]   addr_mux;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [ENTRY_BITS-1:0]  push_entry;
  logic [ENTRY_BITS-1:0]  head;
  logic [ROW_BITS-1:0]    head_row;
  logic [COL_BITS-1:0]    head_col;
  logic [PIXEL_WIDTH-1:0] head_data;

  // Writes are only accepted in RUN so the FIFO can only shrink while a
  // swap is pending; that is what guarantees it drains before the toggle.
  assign host_wr_ready = !reset && !fifo_full && (state == ST_RUN);
  assign push          = host_wr_valid && host_wr_ready;
  // Display reads own the RAM port; the FIFO only drains on free cycles.
  assign pop           = !reset && !disp_req && !fifo_empty;
  assign push_entry    = {host_wr_row, host_wr_col, host_wr_data};
  assign {head_row, head_col, head_data} = head;

  write_fifo #(
    .WIDTH(ENTRY_BITS),
    .DEPTH(WR_FIFO_DEPTH)
  ) u_write_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // RAM port mux; the address is held on idle cycles to avoid needless toggling.
  always_comb begin
    addr_mux  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = head_data;
    if (reset) begin
      addr_mux = '0;
    end else if (disp_req) begin
      addr_mux = pack_addr(bank_q, disp_row, disp_col);
    end else if (pop) begin
      ram_we   = 1'b1;
      addr_mux = pack_addr(~bank_q, head_row, head_col);
    end
  end

  assign ram_addr = addr_mux;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= disp_req;
      if (disp_req || pop) addr_q <= addr_mux;
    end
  end

  // Outputs are forced to their reset values combinationally so they read
  // as reset even in the first cycle reset is high.
  assign disp_valid = valid_q && !reset;
  assign disp_data  = disp_valid ? ram_rdata : '0;

  // The bank flips on entry to SWAP so the new front buffer and the ack
  // become visible in the same cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state  <= ST_RUN;
      bank_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (host_swap_req) state <= ST_SWAP_WAIT;
        end
        ST_SWAP_WAIT: begin
          if (disp_frame_end && fifo_empty && !pop) begin
            state  <= ST_SWAP;
            bank_q <= ~bank_q;
          end
        end
        ST_SWAP: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign host_swap_ack = !reset && (state == ST_SWAP);
  assign active_bank   = !reset && bank_q;

endmodule

// File: doc/framebuffer_arbiter.md
FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter PIXEL_WIDTH, default 18: RGB pixel width, 3 channels x 6 brightness bits.
REQ-002 Parameter WR_FIFO_DEPTH, default 4: host write buffer entries; power of two, minimum 2.
REQ-003 clk_in  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 disp_req  input  1  display read strobe for one pixel, issued by the scan logic.
REQ-006 disp_row  input  4  row of the display read.
REQ-007 disp_col  input  6  column of the display read.
REQ-008 disp_frame_end  input  1  one-cycle pulse after the last state of row 15.
REQ-009 disp_data  output  PIXEL_WIDTH  pixel returned for a display read.
REQ-010 disp_valid  output  1  disp_data qualifier.
REQ-011 host_wr_valid / host_wr_ready  input / output  1 / 1  host write handshake.
REQ-012 host_wr_row, host_wr_col, host_wr_data  input  4, 6, PIXEL_WIDTH  host write payload.
REQ-013 host_swap_req  input  1  pulse requesting a front/back buffer swap.
REQ-014 host_swap_ack  output  1  one-cycle pulse when the swap takes effect.
REQ-015 active_bank  output  1  bank currently displayed (front buffer).
REQ-016 ram_addr  output  11  {bank, row, col} to the single-port frame RAM.
REQ-017 ram_we / ram_wdata / ram_rdata  output / output / input  1 / PIXEL_WIDTH / PIXEL_WIDTH  RAM write enable, write data, read data; RAM read latency 1 cycle.

Function
REQ-018 Display priority: in any cycle with disp_req=1, ram_addr={active_bank,disp_row,disp_col}, ram_we=0.
REQ-019 disp_valid SHALL assert exactly 1 cycle after disp_req, with disp_data=ram_rdata registered from that cycle; back-to-back disp_req gives back-to-back disp_valid.
REQ-020 Host write accepted when host_wr_valid && host_wr_ready; entry {row,col,data} pushed to the FIFO.
REQ-021 host_wr_ready = !fifo_full && state==RUN.
REQ-022 FIFO drain: when disp_req=0 and FIFO non-empty, pop one entry; ram_we=1, ram_addr={~active_bank,row,col}, ram_wdata=data; host writes go only to the back buffer.
REQ-023 Collision: disp_req=1 with FIFO non-empty -> no pop, FIFO contents unchanged.
REQ-024 Push and pop in the same cycle -> occupancy unchanged, order preserved (strict FIFO).
REQ-025 Idle cycles (no disp_req, FIFO empty): ram_we=0, ram_addr holds its last value.
REQ-026 Swap FSM states RUN, SWAP_WAIT, SWAP.
REQ-027 RUN -> SWAP_WAIT on host_swap_req; a disp_frame_end in the same cycle does not complete the swap.
REQ-028 SWAP_WAIT -> SWAP on disp_frame_end when the FIFO is empty and there is no pop that cycle; otherwise remain in SWAP_WAIT until a later frame_end.
REQ-029 SWAP (1 cycle): toggle active_bank, pulse host_swap_ack, -> RUN.
REQ-030 host_swap_req in SWAP_WAIT or SWAP is ignored; no ack is queued.
REQ-031 Writes in flight at a swap land in the old back buffer; an empty FIFO is guaranteed before the toggle.
REQ-032 Display reads at most 64 of every 80 state cycles, so the FIFO drains within 16 free cycles; no starvation logic is required.

Reset
REQ-033 Reset SHALL force: active_bank=0, FIFO empty, state=RUN, ram_we=0, ram_addr=0, disp_valid=0, disp_data=0, host_swap_ack=0, host_wr_ready=0 while reset is high.
REQ-034 Reset mid-swap or with a non-empty FIFO discards pending entries and the swap request; no ack is issued.
REQ-035 host_wr_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-036 Shared package holds ROW_BITS=4, COL_BITS=6, PIXEL_WIDTH default, and the FSM state encoding.
REQ-037 The FIFO is one sub-module, write_fifo: synchronous, parameterised width/depth, with full/empty flags.
REQ-038 The arbitration mux and the swap FSM live in the top module.

Verification
REQ-039 64 consecutive disp_req, cols 0..63, bank 0 preloaded with data=col -> disp_valid for 64 cycles, disp_data=0..63, each 1 cycle after its request.
REQ-040 Host writes 5 pixels during a 64-cycle disp_req burst, depth 4 -> ready drops after 4 accepts; no ram_we during the burst; 4 writes to bank 1 start on the first free cycle, then the 5th is accepted.
REQ-041 host_swap_req with FIFO empty, disp_frame_end 10 cycles later -> ack 1 cycle after frame_end, active_bank 0->1; next display reads address bank 1.
REQ-042 host_swap_req with 3 FIFO entries and frame_end during a disp burst -> no swap at that frame_end; swap at the next frame_end after the FIFO empties.
REQ-043 Reset asserted in SWAP_WAIT with 2 FIFO entries -> no ack, active_bank=0, no further ram_we, ready=1 one cycle after release.
REQ-044 host_swap_req and disp_frame_end in the same cycle -> swap deferred to the following frame_end; only one ack.
